// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM subordinate: word-organised memory with little-endian byte/halfword/word lanes.
// Latency: data phase follows the address phase after WAIT_STATES stall cycles; errors take two cycles.
// Backpressure: stalls the bus with HREADYOUT low during wait states and the first ERROR cycle.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH);
    localparam logic [2:0] WS_RELOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [IDX_W+1:0]        addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    readyout_q, readyout_d;
    logic                    resp_q, resp_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    req_err;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [3:0]              wr_be;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign accept  = HSEL && HREADY && HTRANS[1];
    assign req_err = ({1'b0, HADDR} >= BYTE_LIMIT)
                  || (HSIZE > 3'b010)
                  || ((HSIZE == 3'b001) && HADDR[0])
                  || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

    assign wr_en  = (state_q == ST_DATA) && write_q;
    assign wr_idx = addr_q[IDX_W+1:2];
    assign wr_be  = lane_mask(size_q, addr_q[1:0]);

    // A read leaving WAIT uses the held address; otherwise the live address phase.
    assign rd_idx = (state_q == ST_WAIT) ? addr_q[IDX_W+1:2] : HADDR[IDX_W+1:2];

    // Forward lanes of a write committing on this same edge so back-to-back RAW sees new data.
    always_comb begin
        rd_word = mem_q[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i] && (wr_idx == rd_idx)) begin
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    addr_d  = HADDR[IDX_W+1:0];
                    size_d  = HSIZE[1:0];
                    write_d = HWRITE;
                    cnt_d   = WS_RELOAD;
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        readyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        resp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
        rdata_d    = ((state_d == ST_DATA) && !write_d) ? rd_word : '0;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            rdata_q    <= rdata_d;
            readyout_q <= readyout_d;
            resp_q     <= resp_d;
        end
    end

    // Storage is not cleared by reset; a write still in its data phase at reset is dropped.
    always_ff @(posedge HCLK) begin
        if (HRESETn && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = rdata_q;
    assign HREADYOUT = readyout_q;
    assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 3 and 2 wait states) on one AHB bus,
// directed vector table, a reset-during-wait sequence, and randomized traffic against a byte model.
module tb_ahb_lite_sram_slave;

    localparam int DEPTH = 256;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

    typedef struct {
        int          inst;
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          chk;
        bit          exp_err;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [2:0]  hsel;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata [3];
    logic [2:0]  hreadyout;
    logic [2:0]  hresp;
    logic [1:0]  dp_inst;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mm [3][1024];
    bit         mk [3][1024];
    vec_t       vq[$];
    vec_t       tbl[$];

    always #5 hclk = ~hclk;

    // The bench acts as the response mux: HREADY comes from the slave owning the data phase.
    assign hready = hreadyout[dp_inst];

    ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

    ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

    ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

    function automatic int ws_of(input int inst);
        case (inst)
            1:       return 3;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_xfer(input vec_t v);
        return v.sel && v.trans[1];
    endfunction

    function automatic bit model_err(input logic [2:0] size, input logic [11:0] a);
        int ai = int'(a);
        return (ai >= 4 * DEPTH) || (size > 3'd2)
            || ((size == SZ_H) && (ai % 2 != 0))
            || ((size == SZ_W) && (ai % 4 != 0));
    endfunction

    task automatic model_write(input int inst, input logic [2:0] size, input logic [11:0] a,
                               input logic [31:0] wd);
        int nb = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            int b = int'(a) + i;
            int lane = b % 4;
            mm[inst][b] = wd[8*lane +: 8];
            mk[inst][b] = 1'b1;
        end
    endtask

    task automatic model_read(input int inst, input logic [11:0] a,
                              output logic [31:0] d, output logic [31:0] m);
        int base = int'(a) & ~3;
        d = '0;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            d[8*i +: 8] = mm[inst][base + i];
            m[8*i +: 8] = mk[inst][base + i] ? 8'hFF : 8'h00;
        end
    endtask

    function automatic vec_t mkv(input int inst, input bit sel, input logic [1:0] trans,
                                 input bit wr, input logic [2:0] size, input logic [11:0] addr,
                                 input logic [31:0] wdata, input bit err, input int waits,
                                 input logic [31:0] rdata);
        vec_t v;
        v.inst = inst; v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
        v.addr = addr; v.wdata = wdata; v.chk = 1'b1; v.exp_err = err;
        v.exp_waits = waits; v.exp_rdata = rdata;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int r;
        v.inst = $urandom_range(0, 2);
        v.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        v.trans = (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
        v.wr = 1'($urandom_range(0, 1));
        v.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r < 7)      v.addr = 12'h100 + 12'($urandom_range(0, 63));
        else if (r < 9) v.addr = 12'($urandom_range(0, 1023));
        else            v.addr = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 9) != 0) begin
            if (v.size == SZ_H)      v.addr[0] = 1'b0;
            else if (v.size == SZ_W) v.addr[1:0] = 2'b00;
        end
        v.wdata = $urandom();
        v.chk = 1'b0; v.exp_err = 1'b0; v.exp_waits = 0; v.exp_rdata = '0;
        return v;
    endfunction

    // Pipelined master: presents the next address phase while observing the current data phase.
    task automatic run_queue();
        vec_t dp, ap;
        bit dp_act = 1'b0;
        int waits = 0;
        logic [31:0] exp_d, exp_m;
        while (vq.size() != 0 || dp_act) begin
            if (vq.size() != 0) begin
                ap = vq[0];
            end else begin
                ap = mkv(dp_act ? dp.inst : 0, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0, 1'b0, 0, 32'h0);
            end
            hsel    = ap.sel ? (3'b001 << ap.inst) : 3'b000;
            haddr   = ap.addr;
            htrans  = ap.trans;
            hwrite  = ap.wr;
            hsize   = ap.size;
            hwdata  = (dp_act && dp.wr) ? dp.wdata : $urandom();
            dp_inst = 2'(dp_act ? dp.inst : ap.inst);
            @(negedge hclk);
            if (dp_act) begin
                if (hready) begin
                    chk("wait_count", waits, dp.exp_waits);
                    chk("hresp_done", 32'(hresp[dp.inst]), 32'(dp.exp_err));
                    if (is_xfer(dp) && !dp.exp_err && !dp.wr) begin
                        if (dp.chk) begin
                            exp_d = dp.exp_rdata;
                            exp_m = '1;
                        end else begin
                            model_read(dp.inst, dp.addr, exp_d, exp_m);
                        end
                        chk("hrdata", hrdata[dp.inst] & exp_m, exp_d & exp_m);
                    end else begin
                        chk("hrdata_zero", hrdata[dp.inst], 32'h0);
                    end
                    if (is_xfer(dp) && !model_err(dp.size, dp.addr) && dp.wr) begin
                        model_write(dp.inst, dp.size, dp.addr, dp.wdata);
                    end
                    dp_act = 1'b0;
                end else begin
                    waits++;
                    chk("hresp_stall", 32'(hresp[dp.inst]), 32'(dp.exp_err));
                    chk("hrdata_stall", hrdata[dp.inst], 32'h0);
                    if (waits > 16) begin
                        chk("stall_timeout", waits, dp.exp_waits);
                        vq.delete();
                        dp_act = 1'b0;
                    end
                end
            end
            if (hready && vq.size() != 0) begin
                dp = vq.pop_front();
                if (!dp.chk) begin
                    dp.exp_err   = is_xfer(dp) && model_err(dp.size, dp.addr);
                    dp.exp_waits = !is_xfer(dp) ? 0 : dp.exp_err ? 1 : ws_of(dp.inst);
                end
                dp_act = 1'b1;
                waits  = 0;
            end
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        hresetn = 1'b0; hsel = 3'b000; haddr = 12'h0; htrans = T_IDLE;
        hwrite = 1'b0; hsize = SZ_W; hwdata = 32'h0; dp_inst = 2'd0;

        repeat (2) @(posedge hclk);
        @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_hreadyout", 32'(hreadyout[i]), 32'h1);
            chk("reset_hresp", 32'(hresp[i]), 32'h0);
            chk("reset_hrdata", hrdata[i], 32'h0);
        end
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        //           inst sel trans   wr  size    addr     wdata         err waits rdata
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_W,   12'h010, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h010, 32'h0,        0, 0, 32'hDEADBEEF));
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_W,   12'h020, 32'h00000000, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_SEQ,  1, SZ_B,   12'h021, 32'h0000AA00, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_SEQ,  1, SZ_H,   12'h022, 32'h12340000, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h020, 32'h0,        0, 0, 32'h1234AA00));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_B,   12'h023, 32'h0,        0, 0, 32'h1234AA00));
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_W,   12'h3FC, 32'hCAFEF00D, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h3FC, 32'h0,        0, 0, 32'hCAFEF00D));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h400, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_W,   12'h004, 32'h11111111, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_W,   12'h006, 32'hFFFFFFFF, 1, 1, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h004, 32'h0,        0, 0, 32'h11111111));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, 3'b011, 12'h008, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 1, SZ_H,   12'h005, 32'hFFFFFFFF, 1, 1, 32'h0));
        tbl.push_back(mkv(0, 1, T_IDLE, 1, SZ_W,   12'h004, 32'hFFFFFFFF, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_BUSY, 1, SZ_W,   12'h004, 32'hFFFFFFFF, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, T_NSEQ, 1, SZ_W,   12'h004, 32'hFFFFFFFF, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, T_NSEQ, 0, SZ_W,   12'h004, 32'h0,        0, 0, 32'h11111111));
        tbl.push_back(mkv(1, 1, T_NSEQ, 1, SZ_W,   12'h004, 32'hA5A5A5A5, 0, 3, 32'h0));
        tbl.push_back(mkv(1, 1, T_NSEQ, 0, SZ_W,   12'h004, 32'h0,        0, 3, 32'hA5A5A5A5));
        tbl.push_back(mkv(1, 1, T_NSEQ, 0, SZ_W,   12'h004, 32'h0,        0, 3, 32'hA5A5A5A5));
        tbl.push_back(mkv(1, 1, T_NSEQ, 0, SZ_W,   12'h400, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mkv(1, 1, T_NSEQ, 0, SZ_W,   12'h004, 32'h0,        0, 3, 32'hA5A5A5A5));
        tbl.push_back(mkv(2, 1, T_NSEQ, 1, SZ_W,   12'h030, 32'h00000011, 0, 2, 32'h0));
        for (int i = 0; i < tbl.size(); i++) vq.push_back(tbl[i]);
        run_queue();

        // Reset arrives during the first wait cycle of a byte write; the write must be lost.
        hsel = 3'b100; haddr = 12'h030; htrans = T_NSEQ; hwrite = 1'b1; hsize = SZ_B;
        dp_inst = 2'd2;
        @(posedge hclk);
        #1;
        hsel = 3'b000; htrans = T_IDLE; hwdata = 32'h00000055;
        @(negedge hclk);
        chk("rst_mid_first_wait", 32'(hreadyout[2]), 32'h0);
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rst_mid_hreadyout", 32'(hreadyout[2]), 32'h1);
        chk("rst_mid_hresp", 32'(hresp[2]), 32'h0);
        chk("rst_mid_hrdata", hrdata[2], 32'h0);
        @(posedge hclk);
        #1;
        vq.push_back(mkv(2, 1, T_NSEQ, 0, SZ_W, 12'h030, 32'h0, 0, 2, 32'h00000011));
        run_queue();

        for (int inst = 0; inst < 3; inst++) begin
            for (int w = 0; w < 16; w++) begin
                v = mkv(inst, 1, T_NSEQ, 1, SZ_W, 12'h100 + 12'(4 * w), $urandom(), 0, 0, 32'h0);
                v.chk = 1'b0;
                vq.push_back(v);
            end
        end
        for (int i = 0; i < 600; i++) vq.push_back(rand_vec());
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite subordinate that responds to the HSEL line driven by the address decoder. It provides a word-organised SRAM with a programmable number of wait states and little-endian byte/halfword/word access. Its HRDATA/HREADYOUT/HRESP outputs feed the read-data/response multiplexor. Out-of-range, misaligned or oversized accesses get the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 12, local byte-offset bits of HADDR examined by the slave (upper bits already decoded)
DATA_WIDTH, 32, bus width; fixed at 32 for this block
DEPTH, 256, number of 32-bit words; valid offsets are 0 to 4*DEPTH-1
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer; range 0..7

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESETn  in  1  reset; synchronous, active-low
HSEL  in  1  slave select from decoder
HADDR  in  ADDR_WIDTH  byte address (address phase)
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  000 byte, 001 halfword, 010 word
HREADY  in  1  bus ready from response mux
HWDATA  in  32  write data (data phase)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESETn=0 at an HCLK edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0. Pending transfer abandoned; an uncommitted write is not written. Memory contents are not reset.
- Address phase is accepted when HSEL=1, HREADY=1 and HTRANS[1]=1. The slave registers addr, write, size and an error flag.
- Error flag is set when any of these holds: offset >= 4*DEPTH; HSIZE > 010; halfword with HADDR[0]=1; word with HADDR[1:0]!=00.
- IDLE/BUSY transfers, or HSEL=0 while HREADY=1: no access; next cycle HREADYOUT=1, HRESP=0.
- FSM states:
  - IDLE: waiting. On an accepted transfer go to WAIT if WAIT_STATES>0, to ERR1 if error, else to DATA.
  - WAIT: HREADYOUT=0, HRESP=0; counter counts WAIT_STATES cycles, then DATA.
  - DATA: HREADYOUT=1, HRESP=0. Read: HRDATA=mem[offset>>2], full word, lanes not masked. Write: HWDATA lanes selected by size/HADDR[1:0] are written at the end of this cycle.
  - ERR1: HREADYOUT=0, HRESP=1; no memory access.
  - ERR2: HREADYOUT=1, HRESP=1.
  - An error skips wait states: ERR1 comes immediately after the address phase.
- Pipelining: in DATA/ERR2 the slave samples the next address phase the same cycle (HREADY=1). Back-to-back zero-wait transfers give one transfer per cycle.
- Read-after-write to the same word in consecutive transfers must return the new data (bypass or write-first).
- Byte lanes are little-endian: byte at HADDR[1:0]=n uses HWDATA[8n+7:8n]; halfword at HADDR[1]=h uses HWDATA[16h+15:16h].
- HRDATA=0 in every cycle that is not a read DATA cycle.
- Address phase with HREADY=0 (another slave stalling) is ignored.
- Counter width is 3 bits; it reloads on every accepted transfer.

Test Plan:
- Reset, WAIT_STATES=0: HRESETn=0 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0. Word write 0xDEADBEEF @0x010, then read @0x010 -> HRDATA=0xDEADBEEF with HREADYOUT=1 in the cycle after the read address phase.
- Byte/halfword: word 0x00000000 @0x020, byte write 0xAA @0x021 (HWDATA=0x0000AA00), halfword write 0x1234 @0x022 (HWDATA=0x12340000), then read @0x020 -> 0x1234AA00.
- WAIT_STATES=3, read @0x004 -> HREADYOUT low exactly 3 cycles, then high with data; back-to-back NONSEQ reads -> each takes 4 cycles.
- Errors: read @0x400 (DEPTH=256) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1. Word write @0x006 -> same ERROR pair and memory unchanged. HSIZE=011 -> ERROR.
- HTRANS=IDLE with HSEL=1, and NONSEQ with HSEL=0 -> no memory change, HREADYOUT=1, HRESP=0.
- Reset mid-operation: WAIT_STATES=2, write 0x55 to @0x030, assert HRESETn=0 during the first wait cycle -> after release, read @0x030 returns the prior value.
